dac_write_scheduler: RTL

Owns the DAC SPI master transmit interface: arbitrates 16-bit DAC code requests from the DPLL loop filter and the UART host override. Serialises each granted code as two bytes (MSB first) through the SPI master's DV/Ready handshake. Enforces a minimum inter-write gap and a stuck-transfer timeout. Sits between the loop filter / monitor register bank and SPI_Master_With_Single_CS (i_TX_Count tied to 2).

---
 rtl/dac_sched_pkg.sv | 38 +++
 rtl/dac_req_slot.sv | 43 ++++
 rtl/dac_write_scheduler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/dac_sched_pkg.sv
// Shared FSM states, source/byte-order encodings and small helpers for dac_write_scheduler.
package dac_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_HI,
    ST_WAIT_HI,
    ST_SEND_LO,
    ST_WAIT_LO,
    ST_GAP
  } state_e;

  localparam logic       SRC_LOOP = 1'b0;
  localparam logic       SRC_HOST = 1'b1;
  localparam logic [7:0] DROP_MAX = 8'd255;
  localparam logic       BYTE_HI  = 1'b0;
  localparam logic       BYTE_LO  = 1'b1;

  function automatic logic [7:0] code_byte(input logic [15:0] code, input logic sel);
    return (sel == BYTE_HI) ? code[15:8] : code[7:0];
  endfunction

  function automatic logic [15:0] clamp_code(input logic [15:0] code,
                                             input logic [15:0] lo,
                                             input logic [15:0] hi);
    if (code < lo) return lo;
    if (code > hi) return hi;
    return code;
  endfunction

  // Up to two requests can be dropped in one cycle (loop and host together).
  function automatic logic [7:0] drop_add(input logic [7:0] cnt, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'd0, inc};
    return (sum > {1'b0, DROP_MAX}) ? DROP_MAX : sum[7:0];
  endfunction

endpackage

// File: rtl/dac_req_slot.sv
// One pending DAC request: capture wins over clear; ovr_o flags a valid entry being overwritten.
// Zero-latency flags, one-cycle capture; never stalls the requester.
module dac_req_slot (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        cap_i,
  input  logic [15:0] code_i,
  input  logic        clr_i,
  output logic        vld_o,
  output logic [15:0] code_o,
  output logic        ovr_o
);

  logic        vld_q, vld_d;
  logic [15:0] code_q, code_d;

  always_comb begin
    vld_d  = vld_q;
    code_d = code_q;
    if (cap_i) begin
      vld_d  = 1'b1;
      code_d = code_i;
    end else if (clr_i) begin
      vld_d = 1'b0;
    end
  end

  // A capture in the cycle the old entry is granted is not a loss.
  assign ovr_o  = cap_i & vld_q & ~clr_i;
  assign vld_o  = vld_q;
  assign code_o = code_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      vld_q  <= 1'b0;
      code_q <= 16'h0000;
    end else begin
      vld_q  <= vld_d;
      code_q <= code_d;
    end
  end

endmodule

// File: rtl/dac_write_scheduler.sv
// Arbitrates loop/host DAC codes and sends each as MSB then LSB over the SPI master DV/Ready handshake.
// Grant 1 clk after DV, MSB strobe 1 clk later; waits on Ready with timeout. Optional clamp: DAC_CLAMP_EN.
module dac_write_scheduler
  import dac_sched_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 50,
  parameter int unsigned TIMEOUT_CYCLES = 4095,
  parameter logic [15:0] RESET_CODE     = 16'h8CCD,
  parameter logic [15:0] CODE_MIN       = 16'h0000,
  parameter logic [15:0] CODE_MAX       = 16'hFFFF
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_Loop_DV,
  input  logic [15:0] i_Loop_Code,
  input  logic        i_Host_DV,
  input  logic [15:0] i_Host_Code,
  input  logic        i_Host_Hold,
  input  logic        i_TX_Ready,
  output logic [7:0]  o_TX_Byte,
  output logic        o_TX_DV,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Timeout,
  output logic [15:0] o_Last_Code,
  output logic        o_Last_Src,
  output logic [7:0]  o_Drop_Count
);

  localparam int unsigned CNT_MAX  = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
`ifdef DAC_CLAMP_EN
  localparam logic CLAMP_EN = 1'b1;
`else
  localparam logic CLAMP_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] work_code_q;
  logic        work_src_q;
  logic [7:0]  tx_byte_q;
  logic        done_q, timeout_q;
  logic [15:0] last_code_q;
  logic        last_src_q;
  logic [7:0]  drop_q;
  logic        hold_q;

  logic        loop_vld, host_vld, loop_ovr, host_ovr;
  logic [15:0] loop_code, host_code;
  logic        grant, grant_host, tx_dv, tx_sel, done_d, timeout_d;
  logic        first, tmo_hit;
  logic [15:0] grant_code;
  logic [7:0]  cur_byte;
  logic [1:0]  drop_inc;

  assign grant_host = host_vld;

  dac_req_slot u_loop_slot (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .cap_i   (i_Loop_DV & ~i_Host_Hold),
    .code_i  (i_Loop_Code),
    .clr_i   ((grant & ~grant_host) | (i_Host_Hold & ~hold_q)),
    .vld_o   (loop_vld),
    .code_o  (loop_code),
    .ovr_o   (loop_ovr)
  );

  dac_req_slot u_host_slot (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .cap_i   (i_Host_DV),
    .code_i  (i_Host_Code),
    .clr_i   (grant & grant_host),
    .vld_o   (host_vld),
    .code_o  (host_code),
    .ovr_o   (host_ovr)
  );

  assign drop_inc = {1'b0, (i_Loop_DV & i_Host_Hold) | loop_ovr} + {1'b0, host_ovr};
  assign first    = (cnt_q == '0);
  assign tmo_hit  = (cnt_q == TMO_LAST);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // WAIT_* ignores Ready in its first cycle: the master only drops Ready after seeing DV.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (grant) state_d = ST_SEND_HI;
      ST_SEND_HI: if (i_TX_Ready) state_d = ST_WAIT_HI;
                  else if (tmo_hit) state_d = ST_GAP;
      ST_WAIT_HI: if (!first && i_TX_Ready) state_d = ST_SEND_LO;
                  else if (tmo_hit) state_d = ST_GAP;
      ST_SEND_LO: if (i_TX_Ready) state_d = ST_WAIT_LO;
                  else if (tmo_hit) state_d = ST_GAP;
      ST_WAIT_LO: if (!first && i_TX_Ready) state_d = ST_GAP;
                  else if (tmo_hit) state_d = ST_GAP;
      ST_GAP:     if (cnt_q == GAP_LAST) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant     = 1'b0;
    tx_dv     = 1'b0;
    tx_sel    = BYTE_HI;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE:    grant  = host_vld | loop_vld;
      ST_SEND_HI: tx_dv  = i_TX_Ready;
      ST_SEND_LO: begin
        tx_dv  = i_TX_Ready;
        tx_sel = BYTE_LO;
      end
      ST_WAIT_LO: done_d = ~first & i_TX_Ready;
      default: ;
    endcase
    if (state_q inside {ST_SEND_HI, ST_WAIT_HI, ST_SEND_LO, ST_WAIT_LO})
      timeout_d = (state_d == ST_GAP) & ~done_d;
  end

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (state_d != state_q || state_q == ST_IDLE) cnt_d = '0;
  end

  always_comb begin
    grant_code = grant_host ? host_code : loop_code;
    if (CLAMP_EN) grant_code = clamp_code(grant_code, CODE_MIN, CODE_MAX);
  end

  assign cur_byte = code_byte(work_code_q, tx_sel);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt_q       <= '0;
      work_code_q <= 16'h0000;
      work_src_q  <= SRC_LOOP;
      tx_byte_q   <= 8'h00;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      last_code_q <= RESET_CODE;
      last_src_q  <= SRC_LOOP;
      drop_q      <= 8'h00;
      hold_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      drop_q    <= drop_add(drop_q, drop_inc);
      hold_q    <= i_Host_Hold;
      if (grant) begin
        work_code_q <= grant_code;
        work_src_q  <= grant_host ? SRC_HOST : SRC_LOOP;
      end
      if (tx_dv) tx_byte_q <= cur_byte;
      if (done_d) begin
        last_code_q <= work_code_q;
        last_src_q  <= work_src_q;
      end
    end
  end

  assign o_TX_DV      = tx_dv;
  assign o_TX_Byte    = tx_dv ? cur_byte : tx_byte_q;
  assign o_Busy       = (state_q != ST_IDLE);
  assign o_Done       = done_q;
  assign o_Timeout    = timeout_q;
  assign o_Last_Code  = last_code_q;
  assign o_Last_Src   = last_src_q;
  assign o_Drop_Count = drop_q;

endmodule
